fetch_seq: RTL and testbench

FETCH_SEQ -- requirements
Module: fetch_seq

---
 rtl/fetch_seq.sv | 173 +++++++++++++++++
 tb/tb_fetch_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: walks the PC register through write/read, fetches
// from instruction memory, hands words to decode and applies branch redirects.
module fetch_seq #(
    parameter int unsigned              WORD_SIZE    = 32,
    parameter logic [WORD_SIZE-1:0]     RESET_VECTOR = '0,
    parameter int unsigned              PC_STEP      = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [WORD_SIZE-1:0] i_pc,
    output logic [WORD_SIZE-1:0] o_pc_next,
    output logic                 o_pc_cs,
    output logic                 o_pc_we,
    output logic                 o_pc_oe,
    input  logic                 i_branch_valid,
    input  logic [WORD_SIZE-1:0] i_branch_target,
    input  logic                 i_stall,
    output logic                 o_imem_req,
    output logic [WORD_SIZE-1:0] o_imem_addr,
    input  logic                 i_imem_ack,
    input  logic [WORD_SIZE-1:0] i_imem_data,
    output logic [WORD_SIZE-1:0] o_inst,
    output logic [WORD_SIZE-1:0] o_inst_pc,
    output logic                 o_inst_valid,
    input  logic                 i_inst_ready
);

    localparam logic [WORD_SIZE-1:0] STEP       = WORD_SIZE'(PC_STEP);
    localparam logic [WORD_SIZE-1:0] ALIGN_MASK = ~(WORD_SIZE'(3));

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        READ_PC = 3'd1,
        FETCH   = 3'd2,
        ISSUE   = 3'd3,
        UPDATE  = 3'd4
    } state_t;

    state_t                 r_state;
    logic                   r_wr_phase;
    logic [WORD_SIZE-1:0]   r_pc_q;
    logic                   r_redir_pend;
    logic [WORD_SIZE-1:0]   r_redir_tgt;

    logic [WORD_SIZE-1:0]   r_pc_next;
    logic                   r_pc_cs;
    logic                   r_pc_we;
    logic                   r_pc_oe;
    logic                   r_imem_req;
    logic [WORD_SIZE-1:0]   r_imem_addr;
    logic [WORD_SIZE-1:0]   r_inst;
    logic [WORD_SIZE-1:0]   r_inst_pc;
    logic                   r_inst_valid;

    logic [WORD_SIZE-1:0]   w_branch_tgt;
    logic                   w_redir_now;
    logic [WORD_SIZE-1:0]   w_next_pc;

    assign w_branch_tgt = i_branch_target & ALIGN_MASK;
    assign w_redir_now  = r_redir_pend | i_branch_valid;
    // A pulse landing on the write decision wins over the older stored target.
    assign w_next_pc    = i_branch_valid ? w_branch_tgt :
                          r_redir_pend   ? r_redir_tgt  : r_pc_q + STEP;

    // INIT and UPDATE each take a decision cycle followed by the cycle that shows
    // the write pulse; r_wr_phase marks the second one.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= INIT;
            r_wr_phase   <= 1'b0;
            r_pc_q       <= '0;
            r_redir_pend <= 1'b0;
            r_redir_tgt  <= '0;
            r_pc_next    <= RESET_VECTOR;
            r_pc_cs      <= 1'b0;
            r_pc_we      <= 1'b0;
            r_pc_oe      <= 1'b0;
            r_imem_req   <= 1'b0;
            r_imem_addr  <= '0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_inst_valid <= 1'b0;
        end else begin
            if (i_branch_valid) begin
                r_redir_pend <= 1'b1;
                r_redir_tgt  <= w_branch_tgt;
            end
            case (r_state)
                INIT: begin
                    if (!r_wr_phase) begin
                        r_pc_cs    <= 1'b1;
                        r_pc_we    <= 1'b1;
                        r_pc_oe    <= 1'b0;
                        r_pc_next  <= RESET_VECTOR;
                        r_wr_phase <= 1'b1;
                    end else begin
                        r_pc_cs    <= 1'b1;
                        r_pc_we    <= 1'b0;
                        r_pc_oe    <= 1'b1;
                        r_wr_phase <= 1'b0;
                        r_state    <= READ_PC;
                    end
                end
                READ_PC: begin
                    r_pc_cs <= 1'b0;
                    r_pc_oe <= 1'b0;
                    r_state <= FETCH;
                end
                FETCH: begin
                    // Acks are only meaningful once the request is on the bus.
                    if (!r_imem_req) begin
                        r_pc_q      <= i_pc;
                        r_imem_addr <= i_pc;
                        r_imem_req  <= 1'b1;
                    end else if (i_imem_ack) begin
                        r_imem_req <= 1'b0;
                        if (w_redir_now) begin
                            r_state <= UPDATE;
                        end else begin
                            r_inst       <= i_imem_data;
                            r_inst_pc    <= r_pc_q;
                            r_inst_valid <= 1'b1;
                            r_state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (i_inst_ready) begin
                        r_inst_valid <= 1'b0;
                        r_state      <= UPDATE;
                    end
                end
                UPDATE: begin
                    if (r_wr_phase) begin
                        r_pc_cs    <= 1'b1;
                        r_pc_we    <= 1'b0;
                        r_pc_oe    <= 1'b1;
                        r_wr_phase <= 1'b0;
                        r_state    <= READ_PC;
                    end else if (!i_stall) begin
                        r_pc_cs      <= 1'b1;
                        r_pc_we      <= 1'b1;
                        r_pc_oe      <= 1'b0;
                        r_pc_next    <= w_next_pc;
                        r_redir_pend <= 1'b0;
                        r_wr_phase   <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= INIT;
                    r_wr_phase <= 1'b0;
                end
            endcase
        end
    end

    assign o_pc_next    = r_pc_next;
    assign o_pc_cs      = r_pc_cs;
    assign o_pc_we      = r_pc_we;
    assign o_pc_oe      = r_pc_oe;
    assign o_imem_req   = r_imem_req;
    assign o_imem_addr  = r_imem_addr;
    assign o_inst       = r_inst;
    assign o_inst_pc    = r_inst_pc;
    assign o_inst_valid = r_inst_valid;

`ifndef SYNTHESIS
    a_we_oe: assert property (@(posedge i_clk) disable iff (!i_rst) !(r_pc_we && r_pc_oe));
    a_req:   assert property (@(posedge i_clk) disable iff (!i_rst) r_imem_req |-> (r_state == FETCH));
    a_valid: assert property (@(posedge i_clk) disable iff (!i_rst) r_inst_valid |-> (r_state == ISSUE));
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: PC register and memory models plus a transaction-level
// reference of the expected fetch/issue/write stream.
module tb_fetch_seq;
    localparam logic [31:0] RV = 32'h0;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_pc;
    logic [31:0] o_pc_next;
    logic        o_pc_cs, o_pc_we, o_pc_oe;
    logic        i_branch_valid;
    logic [31:0] i_branch_target;
    logic        i_stall;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_data;
    logic [31:0] o_inst, o_inst_pc;
    logic        o_inst_valid;
    logic        i_inst_ready;

    fetch_seq #(.WORD_SIZE(32), .RESET_VECTOR(RV), .PC_STEP(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_pc(i_pc), .o_pc_next(o_pc_next),
        .o_pc_cs(o_pc_cs), .o_pc_we(o_pc_we), .o_pc_oe(o_pc_oe),
        .i_branch_valid(i_branch_valid), .i_branch_target(i_branch_target),
        .i_stall(i_stall), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_ack(i_imem_ack), .i_imem_data(i_imem_data), .o_inst(o_inst),
        .o_inst_pc(o_inst_pc), .o_inst_valid(o_inst_valid), .i_inst_ready(i_inst_ready)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // PC register: written on cs&we, read data always reflects stored value
    logic [31:0] pc_reg = 32'hBAD0_0000;
    always @(posedge i_clk) if (o_pc_cs && o_pc_we) pc_reg <= o_pc_next;
    assign i_pc = pc_reg;

    // Memory: acks a request after mem_lat cycles
    int   mem_lat  = 1;
    bit   rand_lat = 0;
    int   wcnt     = 0;
    logic mem_ack  = 1'b0;
    logic stray_ack = 1'b0;
    always @(posedge i_clk) begin
        #1;
        mem_ack = 1'b0;
        if (!i_rst || !o_imem_req) begin
            wcnt = 0;
            if (rand_lat) mem_lat = $urandom_range(0, 3);
        end else if (wcnt >= mem_lat) begin
            mem_ack = 1'b1;
            wcnt = 0;
        end else begin
            wcnt++;
        end
    end
    assign i_imem_ack  = mem_ack | stray_ack;
    assign i_imem_data = stray_ack ? 32'hDEAD_BEEF : memword(o_imem_addr);

    // Reference model
    logic [31:0] exp_q[$];
    logic [31:0] issued_q[$];
    bit          m_pend, m_first;
    logic [31:0] m_tgt, m_wr_exp, m_last_fetch;
    int          m_nwr = 0, m_hold = 0, m_last_hold = 0;
    logic        prev_req, prev_stall;

    always @(negedge i_clk) begin
        if (!i_rst) begin
            m_pend = 0; m_first = 1; prev_req = 0; prev_stall = 0; m_hold = 0;
            exp_q.delete(); issued_q.delete();
        end else begin
            chk("we_oe_excl", 64'(o_pc_we & o_pc_oe), 64'd0);
            chk("req_valid_excl", 64'(o_imem_req & o_inst_valid), 64'd0);
            if (o_pc_cs && o_pc_we) begin
                if (m_first) m_wr_exp = RV;
                else begin
                    m_wr_exp = m_pend ? m_tgt : m_last_fetch + 32'd4;
                    chk("stall_gap", 64'(prev_stall), 64'd0);
                end
                chk("pc_write", 64'(o_pc_next), 64'(m_wr_exp));
                m_first = 0; m_pend = 0; m_nwr++;
            end
            if (o_imem_req && !prev_req) begin
                chk("fetch_addr", 64'(o_imem_addr), 64'(m_wr_exp));
                m_last_fetch = m_wr_exp;
            end else if (o_imem_req) begin
                chk("fetch_hold", 64'(o_imem_addr), 64'(m_last_fetch));
            end
            if (o_imem_req && i_imem_ack && !(m_pend || i_branch_valid))
                exp_q.push_back(m_last_fetch);
            if (o_inst_valid) begin
                if (exp_q.size() == 0) chk("spurious_valid", 64'(o_inst_valid), 64'd0);
                else begin
                    chk("inst_pc", 64'(o_inst_pc), 64'(exp_q[0]));
                    chk("inst_data", 64'(o_inst), 64'(memword(exp_q[0])));
                    if (i_inst_ready) begin
                        issued_q.push_back(exp_q.pop_front());
                        m_last_hold = m_hold; m_hold = 0;
                    end else m_hold++;
                end
            end
            if (i_branch_valid) begin
                m_pend = 1;
                m_tgt  = i_branch_target & ~32'd3;
            end
            prev_req = o_imem_req; prev_stall = i_stall;
        end
    end

    task automatic chk_reset_vals();
        chk("rst_cs", 64'(o_pc_cs), 0);      chk("rst_we", 64'(o_pc_we), 0);
        chk("rst_oe", 64'(o_pc_oe), 0);      chk("rst_req", 64'(o_imem_req), 0);
        chk("rst_valid", 64'(o_inst_valid), 0);
        chk("rst_pc_next", 64'(o_pc_next), 64'(RV));
        chk("rst_addr", 64'(o_imem_addr), 0); chk("rst_inst", 64'(o_inst), 0);
        chk("rst_inst_pc", 64'(o_inst_pc), 0);
    endtask

    task automatic do_reset();
        i_rst = 1'b0;
        repeat (3) @(posedge i_clk);
        #1 chk_reset_vals();
        i_rst = 1'b1;
    endtask

    task automatic wait_issued(input int n, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge i_clk); #1;
            if (issued_q.size() >= n) return;
        end
        chk("timeout_issue", 64'(issued_q.size()), 64'(n));
    endtask

    task automatic wait_req_rise(input int budget, output logic [31:0] a);
        logic p;
        p = o_imem_req;
        a = 32'hFFFF_FFFF;
        for (int k = 0; k < budget; k++) begin
            @(negedge i_clk); #1;
            if (o_imem_req && !p) begin a = o_imem_addr; return; end
            p = o_imem_req;
        end
        chk("timeout_req", 64'(o_imem_req), 64'd1);
    endtask

    task automatic wait_valid_pc(input logic [31:0] pc, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge i_clk); #1;
            if (o_inst_valid && o_inst_pc == pc) return;
        end
        chk("timeout_valid", 64'(o_inst_pc), 64'(pc));
    endtask

    task automatic wait_write(input int budget, output logic [31:0] v);
        v = 32'hBAD0_BAD0;
        for (int k = 0; k < budget; k++) begin
            @(negedge i_clk); #1;
            if (o_pc_cs && o_pc_we) begin v = o_pc_next; return; end
        end
        chk("timeout_write", 64'(o_pc_we), 64'd1);
    endtask

    initial begin
        logic [31:0] a, v;
        int n0;
        i_rst = 1'b0; i_branch_valid = 1'b0; i_branch_target = '0;
        i_stall = 1'b0; i_inst_ready = 1'b1;
        #1 chk_reset_vals();

        // in-order sequential fetch
        do_reset();
        wait_issued(3, 300);
        if (issued_q.size() >= 3) begin
            chk("seq_0", 64'(issued_q[0]), 64'h0);
            chk("seq_4", 64'(issued_q[1]), 64'h4);
            chk("seq_8", 64'(issued_q[2]), 64'h8);
        end

        // redirect during fetch discards the word
        do_reset();
        a = 0;
        for (int k = 0; k < 6 && a != 32'h8; k++) wait_req_rise(100, a);
        @(posedge i_clk); #1 i_branch_valid = 1'b1; i_branch_target = 32'h103;
        @(posedge i_clk); #1 i_branch_valid = 1'b0;
        wait_req_rise(100, a);
        chk("redir_fetch", 64'(a), 64'h100);
        chk("discard_8", 64'(issued_q.size()), 64'd2);

        // redirect during issue keeps the instruction
        do_reset();
        wait_issued(1, 200);
        @(posedge i_clk); #1 i_inst_ready = 1'b0;
        wait_valid_pc(32'h4, 200);
        @(posedge i_clk); #1 i_branch_valid = 1'b1; i_branch_target = 32'h200;
        @(posedge i_clk); #1 i_branch_valid = 1'b0;
        @(posedge i_clk); #1 i_inst_ready = 1'b1;
        wait_issued(2, 50);
        chk("hold_cycles", 64'(m_last_hold), 64'd3);
        if (issued_q.size() >= 2) chk("issued_4", 64'(issued_q[1]), 64'h4);
        wait_req_rise(100, a);
        chk("issue_redir_fetch", 64'(a), 64'h200);

        // stall in UPDATE
        do_reset();
        wait_issued(1, 200);
        @(posedge i_clk); #1 i_stall = 1'b1;
        n0 = m_nwr;
        repeat (5) @(posedge i_clk);
        #1 i_stall = 1'b0;
        @(negedge i_clk); #1 chk("stall_no_write", 64'(m_nwr), 64'(n0));
        @(negedge i_clk); #1 chk("stall_one_write", 64'(m_nwr), 64'(n0 + 1));
        chk("stall_write_val", 64'(o_pc_next), 64'h4);
        repeat (3) @(negedge i_clk);
        #1 chk("stall_single", 64'(m_nwr), 64'(n0 + 1));

        // PC wrap at the top of the address space
        @(posedge i_clk); #1 i_branch_valid = 1'b1; i_branch_target = 32'hFFFF_FFFF;
        @(posedge i_clk); #1 i_branch_valid = 1'b0;
        a = 0;
        for (int k = 0; k < 4 && a != 32'hFFFF_FFFC; k++) wait_req_rise(100, a);
        chk("wrap_fetch", 64'(a), 64'hFFFF_FFFC);
        wait_write(100, v);
        chk("wrap_next", 64'(v), 64'h0);

        // reset during an outstanding fetch, late ack afterwards
        do_reset();
        mem_lat = 3;
        wait_req_rise(100, a);
        @(posedge i_clk); #1 i_rst = 1'b0;
        #1 chk_reset_vals();
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b1; stray_ack = 1'b1;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1 stray_ack = 1'b0;
        mem_lat = 1;
        wait_issued(1, 200);
        if (issued_q.size() >= 1) chk("post_reset_pc", 64'(issued_q[0]), 64'(RV));

        // randomized traffic
        do_reset();
        rand_lat = 1;
        for (int k = 0; k < 3000; k++) begin
            @(posedge i_clk); #1;
            i_inst_ready   = ($urandom_range(0, 3) != 0);
            i_stall        = ($urandom_range(0, 4) == 0);
            i_branch_valid = ($urandom_range(0, 11) == 0);
            i_branch_target = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                          : 32'($urandom_range(0, 32'hFFFF));
        end
        @(posedge i_clk); #1;
        i_branch_valid = 1'b0; i_stall = 1'b0; i_inst_ready = 1'b1;
        repeat (20) @(posedge i_clk);
        #1 chk("rand_progress", 64'(issued_q.size() > 50), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1);
    end
endmodule
